// File: rtl/pc_unit.sv
// Fetch-stage program counter: stall hold, branch/jump redirect, trap entry with
// saved EPC, mret return, misaligned-target detection and a circular return
// address stack (RAS) used to predict return targets.
module pc_unit #(
  parameter int unsigned          BIT_WIDTH    = 32,
  parameter logic [BIT_WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [BIT_WIDTH-1:0] TRAP_VECTOR  = BIT_WIDTH'(32'h0000_0100),
  parameter int unsigned          RAS_DEPTH    = 4
) (
  input  logic                         clock_i,
  input  logic                         reset_ni,
  input  logic                         stall_i,
  input  logic                         branch_taken_i,
  input  logic [BIT_WIDTH-1:0]         branch_target_i,
  input  logic                         call_i,
  input  logic                         ret_i,
  input  logic                         trap_req_i,
  input  logic                         mret_i,
  output logic [BIT_WIDTH-1:0]         pc_out_o,
  output logic [BIT_WIDTH-1:0]         pc_plus4_o,
  output logic [BIT_WIDTH-1:0]         epc_out_o,
  output logic                         misaligned_fault_o,
  output logic                         ret_miss_o,
  output logic [$clog2(RAS_DEPTH):0]   ras_count_o
);

  localparam int unsigned PtrW = $clog2(RAS_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(RAS_DEPTH);

  // Which rule of the priority chain applies this cycle.
  typedef enum logic [2:0] {
    ActTrap,
    ActMret,
    ActMisalign,
    ActBranch,
    ActHold,
    ActPop,
    ActMiss,
    ActSeq
  } action_e;

  action_e act;

  logic [BIT_WIDTH-1:0] pc_q, pc_d;
  logic [BIT_WIDTH-1:0] epc_q, epc_d;
  logic [PtrW-1:0]      ptr_q, ptr_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 fault_q, fault_d;
  logic                 miss_q, miss_d;
  logic                 push;
  logic [BIT_WIDTH-1:0] ras_q [RAS_DEPTH];

  logic                 target_misaligned;
  logic                 ras_empty;

  assign pc_plus4_o         = pc_q + BIT_WIDTH'(4);
  assign pc_out_o           = pc_q;
  assign epc_out_o          = epc_q;
  assign misaligned_fault_o = fault_q;
  assign ret_miss_o         = miss_q;
  assign ras_count_o        = cnt_q;

  assign target_misaligned = |branch_target_i[1:0];
  assign ras_empty         = (cnt_q == '0);

  // Priority decode: first matching rule wins.
  always_comb begin
    act = ActSeq;
    if (trap_req_i) begin
      act = ActTrap;
    end else if (mret_i) begin
      act = ActMret;
    end else if (branch_taken_i && target_misaligned) begin
      act = ActMisalign;
    end else if (branch_taken_i) begin
      act = ActBranch;
    end else if (stall_i) begin
      act = ActHold;
    end else if (ret_i && !ras_empty) begin
      act = ActPop;
    end else if (ret_i) begin
      act = ActMiss;
    end
  end

  // Next-state for PC, EPC, RAS pointer/count and the one-cycle pulses.
  always_comb begin
    pc_d    = pc_q;
    epc_d   = epc_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    fault_d = 1'b0;
    miss_d  = 1'b0;
    push    = 1'b0;
    unique case (act)
      ActTrap: begin
        epc_d = pc_q;
        pc_d  = TRAP_VECTOR;
      end
      ActMret: begin
        pc_d = epc_q;
      end
      ActMisalign: begin
        epc_d   = pc_q;
        pc_d    = TRAP_VECTOR;
        fault_d = 1'b1;
      end
      ActBranch: begin
        pc_d = branch_target_i;
        if (call_i) begin
          // Full stack: the pointer still advances, overwriting the oldest entry.
          push  = 1'b1;
          ptr_d = ptr_q + 1'b1;
          if (cnt_q != CntFull) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ActHold: begin
        pc_d = pc_q;
      end
      ActPop: begin
        pc_d  = ras_q[ptr_q];
        ptr_d = ptr_q - 1'b1;
        cnt_d = cnt_q - 1'b1;
      end
      ActMiss: begin
        pc_d   = pc_plus4_o;
        miss_d = 1'b1;
      end
      ActSeq: begin
        pc_d = pc_plus4_o;
      end
    endcase
  end

  // Architectural state with synchronous active-low reset.
  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      pc_q    <= RESET_VECTOR;
      epc_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      fault_q <= 1'b0;
      miss_q  <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
      miss_q  <= miss_d;
    end
  end

  // RAS storage; contents are don't-care after reset so no reset term.
  always_ff @(posedge clock_i) begin
    if (reset_ni && push) begin
      ras_q[ptr_d] <= pc_plus4_o;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: directed scenarios plus randomized traffic,
// checked against a queue-based behavioural model of the fetch PC.
module tb_pc_unit;

  localparam int unsigned Depth = 4;
  localparam logic [31:0] TrapVec = 32'h0000_0100;

  logic        clk;
  logic        rst_n;
  logic        stall, br, call, ret, trap, mret;
  logic [31:0] tgt;
  logic [31:0] pc_out, pc_plus4, epc_out;
  logic        mfault, rmiss;
  logic [2:0]  ras_count;

  int checks;
  int failures;

  pc_unit #(
    .BIT_WIDTH   (32),
    .RESET_VECTOR(32'h0),
    .TRAP_VECTOR (TrapVec),
    .RAS_DEPTH   (Depth)
  ) dut (
    .clock_i           (clk),
    .reset_ni          (rst_n),
    .stall_i           (stall),
    .branch_taken_i    (br),
    .branch_target_i   (tgt),
    .call_i            (call),
    .ret_i             (ret),
    .trap_req_i        (trap),
    .mret_i            (mret),
    .pc_out_o          (pc_out),
    .pc_plus4_o        (pc_plus4),
    .epc_out_o         (epc_out),
    .misaligned_fault_o(mfault),
    .ret_miss_o        (rmiss),
    .ras_count_o       (ras_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] epc;
    logic        mf;
    logic        rm;
    int          cnt;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state: the RAS is just a list of return addresses, newest last.
  logic [31:0] m_pc  = 32'h0;
  logic [31:0] m_epc = 32'h0;
  logic [31:0] m_ras[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, want, $time);
    end
  endtask

  // Apply one cycle of inputs, advance the model, enqueue the expected result.
  task automatic step(input logic r_n, input logic s, input logic b, input logic [31:0] t,
                      input logic c, input logic rt, input logic tr, input logic mr);
    exp_t e;
    @(negedge clk);
    rst_n = r_n; stall = s; br = b; tgt = t; call = c; ret = rt; trap = tr; mret = mr;
    e.mf = 1'b0;
    e.rm = 1'b0;
    if (!r_n) begin
      m_pc  = 32'h0;
      m_epc = 32'h0;
      m_ras.delete();
    end else if (tr) begin
      m_epc = m_pc;
      m_pc  = TrapVec;
    end else if (mr) begin
      m_pc = m_epc;
    end else if (b && (t % 4 != 0)) begin
      m_epc = m_pc;
      m_pc  = TrapVec;
      e.mf  = 1'b1;
    end else if (b) begin
      if (c) begin
        m_ras.push_back(m_pc + 32'd4);
        if (m_ras.size() > Depth) void'(m_ras.pop_front());
      end
      m_pc = t;
    end else if (s) begin
      // hold
    end else if (rt && m_ras.size() > 0) begin
      m_pc = m_ras.pop_back();
    end else if (rt) begin
      m_pc = m_pc + 32'd4;
      e.rm = 1'b1;
    end else begin
      m_pc = m_pc + 32'd4;
    end
    e.pc  = m_pc;
    e.epc = m_epc;
    e.cnt = m_ras.size();
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic go(input logic [31:0] t, input logic c);
    step(1'b1, 1'b0, 1'b1, t, c, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_ret();
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: the DUT presents a new state every cycle; compare against the queue.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_pc", pc_out, e.pc);
        chk("sb_pc_plus4", pc_plus4, e.pc + 32'd4);
        chk("sb_epc", epc_out, e.epc);
        chk("sb_misaligned", {31'b0, mfault}, {31'b0, e.mf});
        chk("sb_ret_miss", {31'b0, rmiss}, {31'b0, e.rm});
        chk("sb_ras_count", {29'b0, ras_count}, e.cnt);
      end
    end
  end

  initial begin
    logic        r_n, s, b, c, rt, tr, mr;
    logic [31:0] t;
    checks   = 0;
    failures = 0;
    rst_n = 1'b0; stall = 1'b0; br = 1'b0; tgt = '0;
    call = 1'b0; ret = 1'b0; trap = 1'b0; mret = 1'b0;

    // Reset, release, free-run.
    do_reset();
    chk("t1_pc_rst0", pc_out, 32'h0);
    do_reset();
    chk("t1_pc_rst1", pc_out, 32'h0);
    chk("t1_ras_count", {29'b0, ras_count}, 32'd0);
    chk("t1_pulses", {30'b0, mfault, rmiss}, 32'd0);
    idle();
    chk("t1_pc_4", pc_out, 32'h4);
    idle();
    chk("t1_pc_8", pc_out, 32'h8);
    idle();
    chk("t1_pc_12", pc_out, 32'hC);

    // Stall hold, then branch overriding stall.
    go(32'h10, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("t2_stall_hold", pc_out, 32'h10);
    end
    step(1'b1, 1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t2_branch_pc", pc_out, 32'h40);
    chk("t2_branch_pc4", pc_plus4, 32'h44);

    // Call/return nesting with an underflow.
    do_reset();
    go(32'h20, 1'b0);
    go(32'h80, 1'b1);
    chk("t3_pc_a", pc_out, 32'h80);
    go(32'hC0, 1'b1);
    chk("t3_pc_b", pc_out, 32'hC0);
    chk("t3_cnt_b", {29'b0, ras_count}, 32'd2);
    do_ret();
    chk("t3_ret1", pc_out, 32'h84);
    do_ret();
    chk("t3_ret2", pc_out, 32'h24);
    chk("t3_miss_no", {31'b0, rmiss}, 32'd0);
    do_ret();
    chk("t3_ret3", pc_out, 32'h28);
    chk("t3_miss_yes", {31'b0, rmiss}, 32'd1);
    chk("t3_cnt_end", {29'b0, ras_count}, 32'd0);

    // RAS overflow drops the oldest entry.
    do_reset();
    go(32'h100, 1'b0);
    for (int i = 2; i <= 6; i++) go(32'(i) << 8, 1'b1);
    chk("t4_cnt_sat", {29'b0, ras_count}, 32'd4);
    for (int i = 5; i >= 2; i--) begin
      do_ret();
      chk("t4_ret", pc_out, (32'(i) << 8) + 32'd4);
    end
    do_ret();
    chk("t4_lost_entry", pc_out, 32'h208);
    chk("t4_miss", {31'b0, rmiss}, 32'd1);

    // Misaligned call target traps, then mret.
    do_reset();
    go(32'h500, 1'b1);
    go(32'h30, 1'b0);
    go(32'h42, 1'b1);
    chk("t5_pc_trap", pc_out, TrapVec);
    chk("t5_epc", epc_out, 32'h30);
    chk("t5_fault", {31'b0, mfault}, 32'd1);
    chk("t5_cnt_kept", {29'b0, ras_count}, 32'd1);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t5_mret_pc", pc_out, 32'h30);
    chk("t5_fault_gone", {31'b0, mfault}, 32'd0);

    // Trap beats mret and branch; PC wrap.
    go(32'h50, 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'h200, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("t6_trap_pc", pc_out, 32'h100);
    chk("t6_trap_epc", epc_out, 32'h50);
    go(32'hFFFF_FFFC, 1'b0);
    idle();
    chk("t6_wrap", pc_out, 32'h0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      r_n = ($urandom_range(0, 63) != 0);
      tr  = ($urandom_range(0, 19) == 0);
      mr  = ($urandom_range(0, 15) == 0);
      b   = ($urandom_range(0, 3) == 0);
      c   = ($urandom_range(0, 1) == 0);
      rt  = ($urandom_range(0, 2) == 0);
      s   = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0:       t = $urandom;
        1:       t = 32'hFFFF_FFF0 | ($urandom & 32'hC);
        default: t = $urandom & 32'h0000_0FFC;
      endcase
      step(r_n, s, b, t, c, rt, tr, mr);
    end

    repeat (3) @(posedge clk);
    #2;
    chk("sb_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
